// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares one register-file write port between ALU and load
// results, with an ALU anti-starvation counter and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int NREGS      = 16,
  parameter int PC_IDX     = 9,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREGS-1:0]  busy,
  output logic              pc_wr_err
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] PC_ADDR    = ADDR_W'(PC_IDX);

  logic [SW-1:0]     starve_cnt_reg, starve_cnt_next;
  logic [NREGS-1:0]  busy_reg, busy_next, issue_hit, wb_hit;
  logic              rf_we_reg, pc_wr_err_reg;
  logic [ADDR_W-1:0] rf_waddr_reg, wb_addr;
  logic [DATA_W-1:0] rf_wdata_reg, wb_data;
  logic              alu_force, alu_fire, mem_fire, wb_fire, issue_fire;

  always_comb begin
    alu_force   = alu_valid && (starve_cnt_reg == STARVE_LIM);
    mem_ready   = !rst && mem_valid && !alu_force;
    alu_ready   = !rst && alu_valid && (!mem_valid || alu_force);
    alu_fire    = alu_valid && alu_ready;
    mem_fire    = mem_valid && mem_ready;
    wb_fire     = alu_fire || mem_fire;
    wb_addr     = mem_fire ? mem_addr : alu_addr;
    wb_data     = mem_fire ? mem_data : alu_data;
    issue_ready = !rst && (issue_addr != PC_ADDR) && !(|(busy_reg & issue_hit));
    issue_fire  = issue_valid && issue_ready;
  end

  // Counter only tracks consecutive ALU losses; any other outcome restarts it.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (alu_valid && mem_fire) begin
      if (starve_cnt_reg != STARVE_LIM)
        starve_cnt_next = starve_cnt_reg + SW'(1);
    end else if (alu_fire || !alu_valid) begin
      starve_cnt_next = '0;
    end
  end

  // Out-of-range addresses match no bit, so they leave the scoreboard alone.
  // A reservation on the same edge as a write to that register keeps it busy.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
      assign issue_hit[gi] = (issue_addr == ADDR_W'(gi));
      assign wb_hit[gi]    = wb_fire && (wb_addr != PC_ADDR) && (wb_addr == ADDR_W'(gi));
      assign busy_next[gi] = (issue_fire && issue_hit[gi]) || (busy_reg[gi] && !wb_hit[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
      busy_reg       <= '0;
      rf_we_reg      <= 1'b0;
      pc_wr_err_reg  <= 1'b0;
      rf_waddr_reg   <= '0;
      rf_wdata_reg   <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      busy_reg       <= busy_next;
      if (wb_fire) begin
        rf_waddr_reg  <= wb_addr;
        rf_wdata_reg  <= wb_data;
        rf_we_reg     <= (wb_addr != PC_ADDR);
        pc_wr_err_reg <= (wb_addr == PC_ADDR);
      end else begin
        rf_we_reg     <= 1'b0;
        pc_wr_err_reg <= 1'b0;
      end
    end
  end

  assign rf_we     = rf_we_reg;
  assign rf_waddr  = rf_waddr_reg;
  assign rf_wdata  = rf_wdata_reg;
  assign busy      = busy_reg;
  assign pc_wr_err = pc_wr_err_reg;

endmodule
